// File: rtl/controlador_pkg.sv
// Shared types and defaults for the multiplier-chain sequencer.
package controlador_pkg;

  typedef enum logic [2:0] {
    StInactivo   = 3'd0,
    StCaptura    = 3'd1,
    StMultiplica = 3'd2,
    StConvierte  = 3'd3,
    StMuestra    = 3'd4,
    StError      = 3'd5
  } estado_t;

  localparam int unsigned CiclosEsperaDef      = 1024;
  localparam int unsigned CiclosAntirreboteDef = 65536;
  localparam int unsigned AnchoContadorDef     = 8;

  // Watchdog width: enough bits to hold ciclos-1.
  function automatic int unsigned anchoTimer(input int unsigned ciclos);
    return (ciclos < 2) ? 1 : $clog2(ciclos);
  endfunction

endpackage

// File: rtl/controlador_secuencia_if.sv
// Start strobes and completion flags between the sequencer and its subsystems.
interface controlador_secuencia_if;
  logic banderaValida;
  logic banderaLista;
  logic banderaConvertida;
  logic pulsoCaptura;
  logic pulsoMultiplicar;
  logic pulsoConvertir;
  logic pulsoDisplay;

  modport master (
    input  banderaValida, banderaLista, banderaConvertida,
    output pulsoCaptura, pulsoMultiplicar, pulsoConvertir, pulsoDisplay
  );

  modport slave (
    output banderaValida, banderaLista, banderaConvertida,
    input  pulsoCaptura, pulsoMultiplicar, pulsoConvertir, pulsoDisplay
  );
endinterface

// File: rtl/controlador_secuencia_detector_flanco.sv
// Start-button conditioning: 2-flop synchroniser, optional debounce, one-cycle inicio.
// Debounce is built only when CONTROLADOR_ANTIRREBOTE_EN is defined.
module detector_flanco #(
  parameter int unsigned CICLOS_ANTIRREBOTE = 65536
) (
  input  logic reloj,
  input  logic reinicio,
  input  logic boton,
  output logic inicio
);

  logic sync1Q, sync2Q;

`ifdef CONTROLADOR_ANTIRREBOTE_EN
  localparam int unsigned AnchoCnt = $clog2(CICLOS_ANTIRREBOTE + 1);
  localparam logic [AnchoCnt-1:0] CntTope   = AnchoCnt'(CICLOS_ANTIRREBOTE);
  localparam logic [AnchoCnt-1:0] CntDisparo = AnchoCnt'(CICLOS_ANTIRREBOTE - 1);

  logic [AnchoCnt-1:0] cntQ;

  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      sync1Q <= 1'b0;
      sync2Q <= 1'b0;
      cntQ   <= '0;
    end else begin
      sync1Q <= boton;
      sync2Q <= sync1Q;
      // Saturating at the top value makes inicio fire once per press.
      if (!sync2Q)             cntQ <= '0;
      else if (cntQ != CntTope) cntQ <= cntQ + 1'b1;
    end
  end

  assign inicio = sync2Q && (cntQ == CntDisparo);
`else
  logic prevQ;
  logic unusedAntirrebote;

  assign unusedAntirrebote = ^CICLOS_ANTIRREBOTE;

  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      sync1Q <= 1'b0;
      sync2Q <= 1'b0;
      prevQ  <= 1'b0;
    end else begin
      sync1Q <= boton;
      sync2Q <= sync1Q;
      prevQ  <= sync2Q;
    end
  end

  assign inicio = sync2Q && !prevQ;
`endif

endmodule

// File: rtl/controlador_secuencia.sv
// Sequencer for read -> multiply -> BCD -> display, with per-state watchdog.
// Optional start debounce: define CONTROLADOR_ANTIRREBOTE_EN.
module controlador_secuencia import controlador_pkg::*; #(
  parameter int unsigned CICLOS_ESPERA      = CiclosEsperaDef,
  parameter int unsigned CICLOS_ANTIRREBOTE = CiclosAntirreboteDef,
  parameter int unsigned ANCHO_CONTADOR     = AnchoContadorDef
) (
  input  logic                      reloj,
  input  logic                      reinicio,
  input  logic                      iniciarMultiplicacion,
  controlador_secuencia_if.master   bus,
  output logic                      ocupado,
  output logic                      banderaError,
  output logic [2:0]                estado,
  output logic [ANCHO_CONTADOR-1:0] contadorOperaciones
);

  localparam int unsigned ANCHO_TIMER = anchoTimer(CICLOS_ESPERA);
  localparam logic [ANCHO_TIMER-1:0] TimerMax = ANCHO_TIMER'(CICLOS_ESPERA - 1);

  logic inicio;

  detector_flanco #(
    .CICLOS_ANTIRREBOTE (CICLOS_ANTIRREBOTE)
  ) uDetector (
    .reloj    (reloj),
    .reinicio (reinicio),
    .boton    (iniciarMultiplicacion),
    .inicio   (inicio)
  );

  estado_t                   estadoQ, estadoD;
  logic [ANCHO_TIMER-1:0]    timerQ, timerD;
  logic [ANCHO_CONTADOR-1:0] contQ, contD;
  logic capQ, capD, mulQ, mulD, convQ, convD, dispQ, dispD;
  logic ocupadoQ, ocupadoD, errorQ, errorD;

  always_comb begin
    estadoD = estadoQ;
    timerD  = timerQ + 1'b1;
    contD   = contQ;
    capD    = 1'b0;
    mulD    = 1'b0;
    convD   = 1'b0;
    dispD   = 1'b0;
    case (estadoQ)
      StInactivo, StMuestra, StError: begin
        if (inicio) begin
          estadoD = StCaptura;
          capD    = 1'b1;
        end
      end
      StCaptura: begin
        if (bus.banderaValida) begin
          estadoD = StMultiplica;
          mulD    = 1'b1;
        end else if (timerQ == TimerMax) begin
          estadoD = StError;
        end
      end
      StMultiplica: begin
        if (bus.banderaLista) begin
          estadoD = StConvierte;
          convD   = 1'b1;
        end else if (timerQ == TimerMax) begin
          estadoD = StError;
        end
      end
      StConvierte: begin
        if (bus.banderaConvertida) begin
          estadoD = StMuestra;
          dispD   = 1'b1;
          contD   = contQ + 1'b1;
        end else if (timerQ == TimerMax) begin
          estadoD = StError;
        end
      end
      default: estadoD = StInactivo;
    endcase
    // Watchdog restarts on every state change.
    if (estadoD != estadoQ) timerD = '0;
    ocupadoD = (estadoD == StCaptura) || (estadoD == StMultiplica) || (estadoD == StConvierte);
    errorD   = (estadoD == StError);
  end

  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      estadoQ  <= StInactivo;
      timerQ   <= '0;
      contQ    <= '0;
      capQ     <= 1'b0;
      mulQ     <= 1'b0;
      convQ    <= 1'b0;
      dispQ    <= 1'b0;
      ocupadoQ <= 1'b0;
      errorQ   <= 1'b0;
    end else begin
      estadoQ  <= estadoD;
      timerQ   <= timerD;
      contQ    <= contD;
      capQ     <= capD;
      mulQ     <= mulD;
      convQ    <= convD;
      dispQ    <= dispD;
      ocupadoQ <= ocupadoD;
      errorQ   <= errorD;
    end
  end

  assign bus.pulsoCaptura     = capQ;
  assign bus.pulsoMultiplicar = mulQ;
  assign bus.pulsoConvertir   = convQ;
  assign bus.pulsoDisplay     = dispQ;
  assign ocupado              = ocupadoQ;
  assign banderaError         = errorQ;
  assign estado               = estadoQ;
  assign contadorOperaciones  = contQ;

endmodule

// File: tb/tb_controlador_secuencia.sv
// Directed bench for controlador_secuencia: normal run, timeout, ignored starts,
// reset abort, counter wrap, flag-on-timeout and (when enabled) debounce.
module tb_controlador_secuencia;

  localparam int unsigned CE = 16;
  localparam int unsigned CA = 8;
  localparam int unsigned AC = 8;
`ifdef CONTROLADOR_ANTIRREBOTE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 3;
`endif

  logic          reloj = 1'b0;
  logic          reinicio;
  logic          boton;
  logic          ocupado;
  logic          banderaError;
  logic [2:0]    estado;
  logic [AC-1:0] contador;
  logic [AC-1:0] expCont;
  int            total = 0;
  int            bad = 0;

  always #5 reloj = ~reloj;

  controlador_secuencia_if bus ();

  controlador_secuencia #(
    .CICLOS_ESPERA      (CE),
    .CICLOS_ANTIRREBOTE (CA),
    .ANCHO_CONTADOR     (AC)
  ) dut (
    .reloj                 (reloj),
    .reinicio              (reinicio),
    .iniciarMultiplicacion (boton),
    .bus                   (bus),
    .ocupado               (ocupado),
    .banderaError          (banderaError),
    .estado                (estado),
    .contadorOperaciones   (contador)
  );

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulsos();
    return {bus.pulsoCaptura, bus.pulsoMultiplicar, bus.pulsoConvertir, bus.pulsoDisplay};
  endfunction

  // Press the button and wait (bounded) for pulsoCaptura.
  task automatic press(input bit hold);
    int n = 0;
    boton = 1'b1;
    while (bus.pulsoCaptura !== 1'b1 && n < LAT + 10) begin
      step();
      n++;
    end
    chk("press_latency", n, LAT);
    chk("press_estado", estado, 3'd1);
    chk("press_pulsos", pulsos(), 4'b1000);
    chk("press_ocupado", ocupado, 1'b1);
    chk("press_error", banderaError, 1'b0);
    if (!hold) boton = 1'b0;
    step();
    chk("press_pulsos_off", pulsos(), 4'b0000);
  endtask

  // which: 1 valida, 2 lista, 3 convertida.
  task automatic ack(input int which);
    step();
    case (which)
      1:       bus.banderaValida = 1'b1;
      2:       bus.banderaLista = 1'b1;
      default: bus.banderaConvertida = 1'b1;
    endcase
    step();
    bus.banderaValida = 1'b0;
    bus.banderaLista = 1'b0;
    bus.banderaConvertida = 1'b0;
    if (which == 3) expCont = expCont + 1'b1;
    chk($sformatf("ack%0d_estado", which), estado, which + 1);
    chk($sformatf("ack%0d_pulsos", which), pulsos(), 4'b1000 >> which);
    chk($sformatf("ack%0d_ocupado", which), ocupado, which != 3);
    chk($sformatf("ack%0d_contador", which), contador, expCont);
    step();
    chk($sformatf("ack%0d_pulsos_off", which), pulsos(), 4'b0000);
  endtask

  initial begin
    bit sawConv;
    bit sawCapt;
    int nCapt;

    reinicio = 1'b0;
    boton = 1'b0;
    bus.banderaValida = 1'b0;
    bus.banderaLista = 1'b0;
    bus.banderaConvertida = 1'b0;
    expCont = '0;
    step();
    step();
    chk("rst_estado", estado, 3'd0);
    chk("rst_pulsos", pulsos(), 4'b0000);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_error", banderaError, 1'b0);
    chk("rst_contador", contador, '0);
    reinicio = 1'b1;
    step();
    step();

    // Normal run.
    press(1'b0);
    ack(1);
    ack(2);
    ack(3);

    // Timeout in MULTIPLICA: entered one cycle before the current sample point.
    press(1'b0);
    ack(1);
    sawConv = 1'b0;
    repeat (14) begin
      step();
      sawConv |= bus.pulsoConvertir;
    end
    chk("to_estado_before", estado, 3'd2);
    step();
    chk("to_estado", estado, 3'd5);
    chk("to_error", banderaError, 1'b1);
    chk("to_ocupado", ocupado, 1'b0);
    chk("to_no_convertir", sawConv, 1'b0);
    press(1'b0);
    ack(1);
    ack(2);
    ack(3);

    // Button held, then re-pressed, while busy.
    press(1'b1);
    ack(1);
    sawCapt = 1'b0;
    boton = 1'b0;
    repeat (3) begin
      step();
      sawCapt |= bus.pulsoCaptura;
    end
    boton = 1'b1;
    repeat (4) begin
      step();
      sawCapt |= bus.pulsoCaptura;
    end
    boton = 1'b0;
    chk("busy_no_captura", sawCapt, 1'b0);
    chk("busy_estado", estado, 3'd2);
    ack(2);
    ack(3);
    repeat (5) begin
      step();
      sawCapt |= bus.pulsoCaptura;
    end
    chk("busy_not_queued", sawCapt, 1'b0);
    chk("busy_estado_final", estado, 3'd4);

    // Reset during CONVIERTE.
    press(1'b0);
    ack(1);
    ack(2);
    reinicio = 1'b0;
    step();
    reinicio = 1'b1;
    expCont = '0;
    chk("abort_estado", estado, 3'd0);
    chk("abort_pulsos", pulsos(), 4'b0000);
    chk("abort_ocupado", ocupado, 1'b0);
    chk("abort_error", banderaError, 1'b0);
    chk("abort_contador", contador, '0);
    bus.banderaConvertida = 1'b1;
    step();
    bus.banderaConvertida = 1'b0;
    chk("abort_no_display", pulsos(), 4'b0000);
    chk("abort_estado_after", estado, 3'd0);

    // Counter wrap after 256 completed runs.
    for (int i = 0; i < 256; i++) begin
      press(1'b0);
      ack(1);
      ack(2);
      ack(3);
    end
    chk("wrap_contador", contador, 8'd0);

    // Flag on the timeout cycle wins.
    press(1'b0);
    ack(1);
    repeat (14) step();
    bus.banderaLista = 1'b1;
    step();
    bus.banderaLista = 1'b0;
    chk("edge_estado", estado, 3'd3);
    chk("edge_pulsos", pulsos(), 4'b0010);
    chk("edge_error", banderaError, 1'b0);
    step();
    ack(3);

`ifdef CONTROLADOR_ANTIRREBOTE_EN
    // Short glitch must not start; a long press starts exactly once.
    nCapt = 0;
    boton = 1'b1;
    repeat (3) step();
    boton = 1'b0;
    repeat (15) begin
      step();
      nCapt += int'(bus.pulsoCaptura);
    end
    chk("deb_glitch", nCapt, 0);
    boton = 1'b1;
    repeat (10) begin
      step();
      nCapt += int'(bus.pulsoCaptura);
    end
    boton = 1'b0;
    repeat (10) begin
      step();
      nCapt += int'(bus.pulsoCaptura);
    end
    chk("deb_press_once", nCapt, 1);
`else
    nCapt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
